// File: rtl/stack_seq_pkg.sv
// Shared types and opcode-class helpers for the stack micro-sequencer.
package stack_seq_pkg;

    typedef enum logic [2:0] {
        OP_PUSHI = 3'd0,
        OP_POP   = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_NOT   = 3'd5,
        OP_DUP   = 3'd6,
        OP_PEEK  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_EXE  = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_e;

    function automatic logic needs_pop2(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic is_unary(input opcode_e op);
        return (op == OP_NOT) || (op == OP_DUP);
    endfunction

    function automatic logic pushes(input opcode_e op);
        return (op == OP_PUSHI) || needs_pop2(op) || is_unary(op);
    endfunction

    function automatic logic reads_tos(input opcode_e op);
        return (op == OP_DUP) || (op == OP_PEEK);
    endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational ALU: A is the first popped operand (TOS), B the second (NOS).
module stack_seq_alu
    import stack_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  opcode_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            OP_NOT:  y = ~a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Multicycle sequencer issuing push/pop/tos strobes to the operand stack
// and executing one stack instruction per accepted start.
module stack_op_sequencer
    import stack_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] stk_dout,
    output logic [WIDTH-1:0] stk_din,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_tos,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [DW-1:0]    depth
);

    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    state_e           state;
    opcode_e          op_q;
    opcode_e          op_in;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] alu_y;
    logic             legal;

    assign op_in = opcode_e'(opcode);

    always_comb begin
        legal = 1'b1;
        case (op_in)
            OP_PUSHI: legal = (depth < FULL);
            OP_POP,
            OP_PEEK,
            OP_NOT:   legal = (depth != '0);
            OP_DUP:   legal = (depth != '0) && (depth < FULL);
            default:  legal = (depth >= DW'(2));
        endcase
    end

    // Strobes depend only on the state register and the latched opcode.
    assign stk_push = (state == S_WR);
    assign stk_tos  = (state == S_RD1) && reads_tos(op_q);
    assign stk_pop  = ((state == S_RD1) && !reads_tos(op_q))
                   || ((state == S_RD2) && needs_pop2(op_q));
    assign stk_din  = !stk_push           ? '0    :
                      (op_q == OP_PUSHI)  ? imm_q : result;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);

    stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (stk_dout),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_PUSHI;
            imm_q  <= '0;
            a_q    <= '0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
            depth  <= '0;
        end else begin
            if (stk_push)
                depth <= depth + DW'(1);
            else if (stk_pop)
                depth <= depth - DW'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        imm_q <= imm;
                        err   <= !legal;
                        if (!legal)
                            state <= S_FIN;
                        else if (op_in == OP_PUSHI)
                            state <= S_WR;
                        else
                            state <= S_RD1;
                    end
                end
                S_RD1: state <= S_RD2;
                S_RD2: begin
                    a_q <= stk_dout;
                    if (pushes(op_q)) begin
                        state <= S_EXE;
                    end else begin
                        result <= stk_dout;
                        zero   <= (stk_dout == '0);
                        state  <= S_FIN;
                    end
                end
                S_EXE: begin
                    result <= alu_y;
                    zero   <= (alu_y == '0);
                    state  <= S_WR;
                end
                S_WR:    state <= S_FIN;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench: behavioural 32-entry stack plus hand-computed expectations.
module tb_stack_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] imm;
    logic [7:0] stk_dout;
    logic [7:0] stk_din;
    logic       stk_push;
    logic       stk_pop;
    logic       stk_tos;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic       zero;
    logic [5:0] depth;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int multi = 0;
    int cyc;
    int p0;
    int q0;

    localparam logic [2:0] PUSHI = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] ANDO = 3'd4, NOTO = 3'd5, DUP = 3'd6, PEEK = 3'd7;

    always #5 clk = ~clk;

    stack_op_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .imm      (imm),
        .stk_dout (stk_dout),
        .stk_din  (stk_din),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_tos  (stk_tos),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .zero     (zero),
        .depth    (depth)
    );

    // Behavioural stack with registered read data.
    logic [7:0] mem [0:31];
    int         sp = 0;

    always @(posedge clk) begin
        if (rst) begin
            sp       <= 0;
            stk_dout <= '0;
        end else begin
            if (stk_pop && sp > 0) begin
                stk_dout <= mem[sp-1];
                sp       <= sp - 1;
            end else if (stk_tos && sp > 0) begin
                stk_dout <= mem[sp-1];
            end
            if (stk_push && sp < 32) begin
                mem[sp] <= stk_din;
                sp      <= sp + 1;
            end
            if (stk_push) push_cnt <= push_cnt + 1;
            if (stk_pop)  pop_cnt  <= pop_cnt + 1;
            if (32'(stk_push) + 32'(stk_pop) + 32'(stk_tos) > 1)
                multi <= multi + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Ends at the negedge of the done cycle; cyc = cycle index of done.
    task automatic do_op(input logic [2:0] op, input logic [7:0] val);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        imm    = val;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("timeout_done", 0, 1);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        opcode = '0;
        imm    = '0;
        do_reset();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_depth", depth, 0);
        chk("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
        chk("rst_din", stk_din, 0);

        do_op(PUSHI, 8'd5);
        chk("pushi_cyc", cyc, 2);
        do_op(PUSHI, 8'd3);
        do_op(SUB, 8'd0);
        chk("sub_cyc", cyc, 5);
        chk("sub_res", result, 2);
        chk("sub_zero", zero, 0);
        chk("sub_err", err, 0);
        chk("sub_depth", depth, 1);
        do_op(POP, 8'd0);
        chk("pop_cyc", cyc, 3);
        chk("pop_res", result, 2);
        chk("pop_depth", depth, 0);

        do_op(PUSHI, 8'd200);
        do_op(PUSHI, 8'd100);
        do_op(ADD, 8'd0);
        chk("add_wrap", result, 44);
        chk("add_depth", depth, 1);
        do_op(PUSHI, 8'd44);
        do_op(SUB, 8'd0);
        chk("sub0_res", result, 0);
        chk("sub0_zero", zero, 1);
        chk("sub0_depth", depth, 1);

        do_reset();
        p0 = push_cnt;
        q0 = pop_cnt;
        do_op(POP, 8'd0);
        chk("upop_cyc", cyc, 1);
        chk("upop_err", err, 1);
        chk("upop_nopop", pop_cnt - q0, 0);
        chk("upop_depth", depth, 0);
        do_op(PUSHI, 8'd7);
        chk("err_clear", err, 0);
        do_op(ADD, 8'd0);
        chk("uadd_err", err, 1);
        chk("uadd_cyc", cyc, 1);
        chk("uadd_depth", depth, 1);
        chk("uadd_res", result, 0);

        do_reset();
        for (int i = 0; i < 32; i++) do_op(PUSHI, 8'(i));
        chk("full_depth", depth, 32);
        p0 = push_cnt;
        do_op(PUSHI, 8'd99);
        chk("ovf_err", err, 1);
        chk("ovf_nopush", push_cnt - p0, 0);
        do_op(DUP, 8'd0);
        chk("dup_ovf_err", err, 1);
        chk("dup_ovf_nopush", push_cnt - p0, 0);
        do_op(PEEK, 8'd0);
        chk("peek_err", err, 0);
        chk("peek_cyc", cyc, 3);
        chk("peek_res", result, 31);
        chk("peek_depth", depth, 32);

        do_reset();
        do_op(PUSHI, 8'h0F);
        do_op(NOTO, 8'd0);
        chk("not_cyc", cyc, 5);
        chk("not_res", result, 'hF0);
        do_op(DUP, 8'd0);
        chk("dup_res", result, 'hF0);
        chk("dup_depth", depth, 2);

        // AND with start held high for the whole instruction.
        p0 = push_cnt;
        q0 = pop_cnt;
        @(negedge clk);
        start  = 1'b1;
        opcode = ANDO;
        cyc    = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 20);
        start = 1'b0;
        chk("hold_cyc", cyc, 5);
        @(negedge clk);
        @(negedge clk);
        chk("and_res", result, 'hF0);
        chk("and_depth", depth, 1);
        chk("hold_busy", busy, 0);
        chk("hold_push", push_cnt - p0, 1);
        chk("hold_pop", pop_cnt - q0, 2);

        do_op(PUSHI, 8'd9);
        do_op(PUSHI, 8'd4);
        chk("pre_abort_depth", depth, 3);
        p0 = push_cnt;
        @(negedge clk);
        start  = 1'b1;
        opcode = ADD;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_depth", depth, 0);
        chk("abort_res", result, 0);
        chk("abort_done", done, 0);
        repeat (4) @(negedge clk);
        chk("abort_nopush", push_cnt - p0, 0);
        chk("abort_idle", busy, 0);
        chk("one_strobe", multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
